// File: rtl/led_blink_scheduler.sv
// -----------------------------------------------------------------------------
// led_blink_scheduler
//
// Round-robin scheduler that shares one status LED among NUM_REQ requesters.
// A granted requester receives one fixed blink burst of BLINKS on/off pairs,
// each phase lasting HALF_PERIOD clocks. The burst is followed by a dark gap of
// GAP_CYCLES clocks before the next grant. A requester that drops its request
// mid-burst aborts the burst. Requests are only arbitrated while idle.
//
// Ports
//   clk    in   1        system clock
//   rst    in   1        synchronous reset, active-high
//   req    in   NUM_REQ  level requests, held high for the whole burst
//   grant  out  NUM_REQ  one-hot owner of the LED, zero outside BLINK
//   busy   out  1        high while in BLINK or GAP
//   done   out  1        one-cycle pulse when a burst completes normally
//   led    out  1        LED drive, active-high
//
// All outputs are registered. After reset req[0] has first priority.
// -----------------------------------------------------------------------------
module led_blink_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int HALF_PERIOD = 20_000_000,
   parameter int BLINKS      = 5,
   parameter int GAP_CYCLES  = 20_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               busy,
   output logic               done,
   output logic               led
);

   // Counter widths; a width of at least one bit keeps degenerate parameter
   // values (e.g. GAP_CYCLES == 1) legal.
   localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int GW = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;
   localparam int TW = $clog2(2 * BLINKS + 1);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TOG_LAST = TW'(2 * BLINKS - 1);
   localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLINK = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Registered state
   state_t              state;
   logic [PW-1:0]       phase_cnt;
   logic [TW-1:0]       tog_cnt;
   logic [GW-1:0]       gap_cnt;
   logic [IW-1:0]       rr_ptr;

   // Next-state values
   state_t              state_n;
   logic [PW-1:0]       phase_n;
   logic [TW-1:0]       tog_n;
   logic [GW-1:0]       gap_n;
   logic [IW-1:0]       rr_n;
   logic [NUM_REQ-1:0]  grant_n;
   logic                busy_n;
   logic                done_n;
   logic                led_n;

   // Round-robin pick
   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       cand;

   // Search upward from rr_ptr+1 (mod NUM_REQ); the last candidate visited is
   // rr_ptr itself, so a lone requester is re-granted after its own burst.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IW'((32'(rr_ptr) + i) % NUM_REQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n = state;
      phase_n = phase_cnt;
      tog_n   = tog_cnt;
      gap_n   = gap_cnt;
      rr_n    = rr_ptr;
      grant_n = grant;
      busy_n  = busy;
      done_n  = 1'b0;
      led_n   = led;

      unique case (state)
         IDLE: begin
            led_n   = 1'b0;
            grant_n = '0;
            busy_n  = 1'b0;
            if (pick_found) begin
               grant_n[pick_idx] = 1'b1;
               rr_n    = pick_idx;
               led_n   = 1'b1;
               busy_n  = 1'b1;
               phase_n = '0;
               tog_n   = '0;
               state_n = BLINK;
            end
         end

         BLINK: begin
            busy_n = 1'b1;
            if ((req & grant) == '0) begin
               // Owner released its request: abort, no done pulse. This check
               // comes first so it wins over a coincident final toggle.
               led_n   = 1'b0;
               grant_n = '0;
               phase_n = '0;
               tog_n   = '0;
               gap_n   = '0;
               state_n = GAP;
            end else if (phase_cnt == PH_LAST) begin
               phase_n = '0;
               if (tog_cnt == TOG_LAST) begin
                  // Final phase boundary: LED is already dark after an odd
                  // number of toggles, so it is held low going into GAP.
                  done_n  = 1'b1;
                  led_n   = 1'b0;
                  grant_n = '0;
                  tog_n   = '0;
                  gap_n   = '0;
                  state_n = GAP;
               end else begin
                  led_n = ~led;
                  tog_n = tog_cnt + TW'(1);
               end
            end else begin
               phase_n = phase_cnt + PW'(1);
            end
         end

         GAP: begin
            led_n   = 1'b0;
            grant_n = '0;
            busy_n  = 1'b1;
            if (gap_cnt == GAP_LAST) begin
               gap_n   = '0;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               gap_n = gap_cnt + GW'(1);
            end
         end

         default: begin
            led_n   = 1'b0;
            grant_n = '0;
            busy_n  = 1'b0;
            phase_n = '0;
            tog_n   = '0;
            gap_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase_cnt <= '0;
         tog_cnt   <= '0;
         gap_cnt   <= '0;
         rr_ptr    <= PTR_INIT;
         grant     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         led       <= 1'b0;
      end else begin
         state     <= state_n;
         phase_cnt <= phase_n;
         tog_cnt   <= tog_n;
         gap_cnt   <= gap_n;
         rr_ptr    <= rr_n;
         grant     <= grant_n;
         busy      <= busy_n;
         done      <= done_n;
         led       <= led_n;
      end
   end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// -----------------------------------------------------------------------------
// tb_led_blink_scheduler
//
// Directed bench for led_blink_scheduler with small timing parameters.
// Expected per-cycle outputs are queued as stimulus is applied and popped one
// entry per clock when the outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_led_blink_scheduler;

   localparam int HP   = 4;
   localparam int BL   = 3;
   localparam int GP   = 2;
   localparam int BLEN = 2 * BL * HP;   // BLINK cycles per burst

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic       busy;
   logic       done;
   logic       led;

   always #5 clk = ~clk;

   led_blink_scheduler #(
      .NUM_REQ     (4),
      .HALF_PERIOD (HP),
      .BLINKS      (BL),
      .GAP_CYCLES  (GP)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .grant (grant),
      .busy  (busy),
      .done  (done),
      .led   (led)
   );

   typedef struct {
      string      tag;
      logic [3:0] g;
      logic       l;
      logic       b;
      logic       d;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input string tag, input logic [3:0] g,
                       input logic l, input logic b, input logic d);
      exp_t e;
      e.tag = tag;
      e.g   = g;
      e.l   = l;
      e.b   = b;
      e.d   = d;
      sb.push_back(e);
   endtask

   // Burst timeline relative to the first granted cycle t=0:
   //   t <  BLEN        : owner granted, LED on in even half-periods
   //   t == BLEN        : GAP, done pulse
   //   t <  BLEN+GP     : GAP
   //   t == BLEN+GP     : IDLE
   task automatic push_burst(input string tag, input logic [3:0] owner,
                             input int t_from, input int t_to);
      for (int t = t_from; t <= t_to; t++) begin
         if (t < BLEN)
            push(tag, owner, ((t / HP) % 2) == 0, 1'b1, 1'b0);
         else if (t < BLEN + GP)
            push(tag, 4'b0000, 1'b0, 1'b1, t == BLEN);
         else
            push(tag, 4'b0000, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic step(input int n);
      exp_t e;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (grant === e.g) else begin
               errors++;
               $error("FAIL %s grant: observed %b expected %b", e.tag, grant, e.g);
            end
            checks++;
            assert (led === e.l) else begin
               errors++;
               $error("FAIL %s led: observed %b expected %b", e.tag, led, e.l);
            end
            checks++;
            assert (busy === e.b) else begin
               errors++;
               $error("FAIL %s busy: observed %b expected %b", e.tag, busy, e.b);
            end
            checks++;
            assert (done === e.d) else begin
               errors++;
               $error("FAIL %s done: observed %b expected %b", e.tag, done, e.d);
            end
         end
         checks++;
         assert ($onehot0(grant) && (grant != 4'b0000 || led === 1'b0)) else begin
            errors++;
            $error("FAIL invariant: observed grant=%b led=%b, expected one-hot-or-zero grant and dark LED when ungranted",
                   grant, led);
         end
      end
   endtask

   initial begin
      // Reset held two cycles with every request asserted
      rst = 1'b1;
      req = 4'b1111;
      push("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
      push("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(2);
      rst = 1'b0;
      req = 4'b0000;
      push("reset_after", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1);

      // Single burst from req[0], then re-grant at cycle 28
      req = 4'b0001;
      push_burst("single", 4'b0001, 0, BLEN + GP);
      step(BLEN + GP + 1);
      push_burst("single_next", 4'b0001, 0, 0);
      step(1);

      // Round-robin; req[1]/req[3] rising mid-burst do not disturb it
      req = 4'b1011;
      push_burst("rr0", 4'b0001, 1, BLEN + GP);
      push_burst("rr1", 4'b0010, 0, BLEN + GP);
      push_burst("rr2", 4'b1000, 0, BLEN + GP);
      push_burst("rr3", 4'b0001, 0, BLEN + GP);
      step(4 * (BLEN + GP + 1) - 1);
      req = 4'b0000;
      push("rr_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1);

      // Abort: req[2] dropped after 10 granted cycles
      req = 4'b0100;
      push_burst("abort_blink", 4'b0100, 0, 9);
      step(10);
      req = 4'b0000;
      push("abort_gap", 4'b0000, 1'b0, 1'b1, 1'b0);
      push("abort_gap", 4'b0000, 1'b0, 1'b1, 1'b0);
      push("abort_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(3);

      // Reset mid-burst, then req[0] wins over req[1]
      req = 4'b0011;
      push_burst("pre_rst", 4'b0001, 0, 6);
      step(7);
      rst = 1'b1;
      push("mid_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1);
      rst = 1'b0;
      push_burst("post_rst", 4'b0001, 0, BLEN + GP);
      step(BLEN + GP + 1);
      req = 4'b0000;
      push("post_rst_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1);

      // Late request: req[3] appears during the GAP of a req[1] burst
      req = 4'b0010;
      push_burst("late_own", 4'b0010, 0, BLEN);
      step(BLEN + 1);
      req = 4'b1000;
      push_burst("late_own", 4'b0010, BLEN + 1, BLEN + GP);
      push_burst("late", 4'b1000, 0, BLEN + GP);
      step(GP + BLEN + GP + 1);
      req = 4'b0000;
      push("late_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout at %0t, expected completion", $time);
      $fatal(1, "simulation time limit reached");
   end

endmodule
